// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for the shared 16-bit SRAM-style word port: system side (A)
// and loader/DMA side (B), round-robin on contention, fixed strobe window per access.
module sram_port_arbiter #(
  parameter int unsigned ACC_CYC = 2,
  parameter int unsigned ADDR_W  = 18
) (
  input  logic              clk_i,
  input  logic              reset_i,

  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [1:0]        a_be_i,
  input  logic [15:0]       a_wdata_i,
  output logic              a_ack_o,
  output logic [15:0]       a_rdata_o,

  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [1:0]        b_be_i,
  input  logic [15:0]       b_wdata_i,
  output logic              b_ack_o,
  output logic [15:0]       b_rdata_o,

  output logic [ADDR_W-1:0] ram_adr_o,
  output logic              ram_cs_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o,
  output logic              ram_lb_n_o,
  output logic              ram_ub_n_o,
  output logic [15:0]       ram_dout_o,
  input  logic [15:0]       ram_din_i
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gnt_b_q, gnt_b_d;
  logic               last_b_q, last_b_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [15:0]        dout_q, dout_d;
  logic               cs_n_q, cs_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               lb_n_q, lb_n_d;
  logic               ub_n_q, ub_n_d;
  logic               a_ack_q, a_ack_d;
  logic               b_ack_q, b_ack_d;
  logic [15:0]        a_rdata_q, a_rdata_d;
  logic [15:0]        b_rdata_q, b_rdata_d;

  // B wins when it is the only requester, or on contention when A was served last.
  logic              pick_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_be;
  logic [15:0]       sel_wdata;

  assign pick_b    = b_req_i & (~a_req_i | ~last_b_q);
  assign sel_we    = pick_b ? b_we_i    : a_we_i;
  assign sel_addr  = pick_b ? b_addr_i  : a_addr_i;
  assign sel_be    = pick_b ? b_be_i    : a_be_i;
  assign sel_wdata = pick_b ? b_wdata_i : a_wdata_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_b_d   = gnt_b_q;
    last_b_d  = last_b_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dout_d    = dout_q;
    cs_n_d    = cs_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    lb_n_d    = lb_n_q;
    ub_n_d    = ub_n_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (a_req_i || b_req_i) begin
          gnt_b_d  = pick_b;
          last_b_d = pick_b;
          we_d     = sel_we;
          adr_d    = sel_addr;
          dout_d   = sel_wdata;
          cnt_d    = CNT_LOAD;
          cs_n_d   = 1'b0;
          oe_n_d   = sel_we;
          we_n_d   = ~sel_we;
          lb_n_d   = ~sel_be[0];
          ub_n_d   = ~sel_be[1];
          state_d  = S_ACCESS;
        end
      end

      S_ACCESS: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          // Last strobe cycle: ram_din is still driven by the addressed bank.
          if (!we_q) begin
            if (gnt_b_q) b_rdata_d = ram_din_i;
            else         a_rdata_d = ram_din_i;
          end
          a_ack_d = ~gnt_b_q;
          b_ack_d = gnt_b_q;
          cs_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          lb_n_d  = 1'b1;
          ub_n_d  = 1'b1;
          state_d = S_ACK;
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        cs_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gnt_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dout_q    <= '0;
      cs_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_b_q   <= gnt_b_d;
      last_b_q  <= last_b_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dout_q    <= dout_d;
      cs_n_q    <= cs_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      lb_n_q    <= lb_n_d;
      ub_n_q    <= ub_n_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign ram_adr_o  = adr_q;
  assign ram_dout_o = dout_q;
  assign ram_cs_n_o = cs_n_q;
  assign ram_oe_n_o = oe_n_q;
  assign ram_we_n_o = we_n_q;
  assign ram_lb_n_o = lb_n_q;
  assign ram_ub_n_o = ub_n_q;
  assign a_ack_o    = a_ack_q;
  assign b_ack_o    = b_ack_q;
  assign a_rdata_o  = a_rdata_q;
  assign b_rdata_o  = b_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural word memory on the main instance,
// ack scoreboard for ordering/read data, plus ACC_CYC=1 and ACC_CYC=4 instances.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  int          total = 0;
  int          bad = 0;

  always #20 clk = ~clk;

  // main instance (ACC_CYC=2)
  logic        a_req, a_we, b_req, b_we;
  logic [17:0] a_addr, b_addr;
  logic [1:0]  a_be, b_be;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic [17:0] ram_adr;
  logic        ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;
  logic [15:0] ram_dout, ram_din;
  logic [4:0]  strb;

  assign strb = {ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n};

  sram_port_arbiter #(.ACC_CYC(2), .ADDR_W(18)) u_dut (
    .clk_i(clk), .reset_i(reset),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_be_i(a_be), .a_wdata_i(a_wdata),
    .a_ack_o(a_ack), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_be_i(b_be), .b_wdata_i(b_wdata),
    .b_ack_o(b_ack), .b_rdata_o(b_rdata),
    .ram_adr_o(ram_adr), .ram_cs_n_o(ram_cs_n), .ram_oe_n_o(ram_oe_n), .ram_we_n_o(ram_we_n),
    .ram_lb_n_o(ram_lb_n), .ram_ub_n_o(ram_ub_n), .ram_dout_o(ram_dout), .ram_din_i(ram_din)
  );

  logic [15:0] mem [0:(1<<18)-1];
  assign ram_din = mem[ram_adr];

  always @(posedge clk) begin
    if (!ram_cs_n && !ram_we_n) begin
      if (!ram_lb_n) mem[ram_adr][7:0]  <= ram_dout[7:0];
      if (!ram_ub_n) mem[ram_adr][15:8] <= ram_dout[15:8];
    end
  end

  // parameter instances share one A-side stimulus; B side idle
  logic        p_req, p_we;
  logic [17:0] p_addr;
  logic [1:0]  p_be;
  logic [15:0] p_wdata;
  logic        p1_ack, p1_back, p4_ack, p4_back;
  logic [15:0] p1_rdata, p1_brdata, p4_rdata, p4_brdata;
  logic [17:0] p1_adr, p4_adr;
  logic        p1_cs_n, p1_oe_n, p1_we_n, p1_lb_n, p1_ub_n;
  logic        p4_cs_n, p4_oe_n, p4_we_n, p4_lb_n, p4_ub_n;
  logic [15:0] p1_dout, p4_dout, p1_din, p4_din;
  logic [4:0]  p1_strb, p4_strb;

  assign p1_strb = {p1_cs_n, p1_oe_n, p1_we_n, p1_lb_n, p1_ub_n};
  assign p4_strb = {p4_cs_n, p4_oe_n, p4_we_n, p4_lb_n, p4_ub_n};
  assign p1_din  = p1_adr[15:0] ^ 16'hC3C3;
  assign p4_din  = p4_adr[15:0] ^ 16'hC3C3;

  sram_port_arbiter #(.ACC_CYC(1), .ADDR_W(18)) u_p1 (
    .clk_i(clk), .reset_i(reset),
    .a_req_i(p_req), .a_we_i(p_we), .a_addr_i(p_addr), .a_be_i(p_be), .a_wdata_i(p_wdata),
    .a_ack_o(p1_ack), .a_rdata_o(p1_rdata),
    .b_req_i(1'b0), .b_we_i(1'b0), .b_addr_i(18'h0), .b_be_i(2'b00), .b_wdata_i(16'h0),
    .b_ack_o(p1_back), .b_rdata_o(p1_brdata),
    .ram_adr_o(p1_adr), .ram_cs_n_o(p1_cs_n), .ram_oe_n_o(p1_oe_n), .ram_we_n_o(p1_we_n),
    .ram_lb_n_o(p1_lb_n), .ram_ub_n_o(p1_ub_n), .ram_dout_o(p1_dout), .ram_din_i(p1_din)
  );

  sram_port_arbiter #(.ACC_CYC(4), .ADDR_W(18)) u_p4 (
    .clk_i(clk), .reset_i(reset),
    .a_req_i(p_req), .a_we_i(p_we), .a_addr_i(p_addr), .a_be_i(p_be), .a_wdata_i(p_wdata),
    .a_ack_o(p4_ack), .a_rdata_o(p4_rdata),
    .b_req_i(1'b0), .b_we_i(1'b0), .b_addr_i(18'h0), .b_be_i(2'b00), .b_wdata_i(16'h0),
    .b_ack_o(p4_back), .b_rdata_o(p4_brdata),
    .ram_adr_o(p4_adr), .ram_cs_n_o(p4_cs_n), .ram_oe_n_o(p4_oe_n), .ram_we_n_o(p4_we_n),
    .ram_lb_n_o(p4_lb_n), .ram_ub_n_o(p4_ub_n), .ram_dout_o(p4_dout), .ram_din_i(p4_din)
  );

  // scoreboard: one entry per expected ack of the main instance, in grant order
  typedef struct {
    bit          port_b;
    bit          is_read;
    logic [15:0] data;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (a_ack === 1'b1 && b_ack === 1'b1) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL dual_ack: a_ack=%b b_ack=%b, want only one", a_ack, b_ack);
    end else if (a_ack === 1'b1 || b_ack === 1'b1) begin
      total = total + 1;
      if (sbq.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_ack: a_ack=%b b_ack=%b with no access outstanding", a_ack, b_ack);
      end else begin
        e = sbq.pop_front();
        if (b_ack !== e.port_b) begin
          bad = bad + 1;
          $display("FAIL ack_port: got b_ack=%b want port_b=%b", b_ack, e.port_b);
        end else if (e.is_read && ((e.port_b ? b_rdata : a_rdata) !== e.data)) begin
          bad = bad + 1;
          $display("FAIL rdata: port_b=%b got %h want %h", e.port_b,
                   e.port_b ? b_rdata : a_rdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit req, input bit we, input logic [17:0] addr,
                         input logic [1:0] be, input logic [15:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_be = be; a_wdata = wd;
  endtask

  task automatic drive_b(input bit req, input bit we, input logic [17:0] addr,
                         input logic [1:0] be, input logic [15:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_be = be; b_wdata = wd;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_a(0, 0, 18'h0, 2'b00, 16'h0);
    drive_b(0, 0, 18'h0, 2'b00, 16'h0);
    p_req = 1'b0; p_we = 1'b0; p_addr = 18'h0; p_be = 2'b00; p_wdata = 16'h0;
    tick();
    tick();
    total = total + 1;
    if (strb !== 5'b11111) begin bad = bad + 1; $display("FAIL rst_strobes: got %b want 11111", strb); end
    total = total + 1;
    if (ram_adr !== 18'h0 || ram_dout !== 16'h0) begin
      bad = bad + 1; $display("FAIL rst_adr_dout: got %h/%h want 0/0", ram_adr, ram_dout);
    end
    total = total + 1;
    if ({a_ack, b_ack} !== 2'b00 || a_rdata !== 16'h0 || b_rdata !== 16'h0) begin
      bad = bad + 1;
      $display("FAIL rst_ack_rdata: got ack=%b%b rdata=%h/%h want 00 0/0", a_ack, b_ack, a_rdata, b_rdata);
    end
    total = total + 1;
    if (p1_strb !== 5'b11111 || p4_strb !== 5'b11111) begin
      bad = bad + 1; $display("FAIL rst_param_strobes: got %b/%b want 11111", p1_strb, p4_strb);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    mem[18'h08010] = 16'h1234;
    sbq.push_back('{port_b: 1'b0, is_read: 1'b1, data: 16'h1234});
    drive_a(1, 0, 18'h08010, 2'b11, 16'h0);
    tick();
    total = total + 1;
    if (strb !== 5'b00100 || ram_adr !== 18'h08010) begin
      bad = bad + 1; $display("FAIL rd_c1: got strb=%b adr=%h want 00100 08010", strb, ram_adr);
    end
    drive_a(0, 1, 18'h3FFFF, 2'b00, 16'hFFFF);
    tick();
    total = total + 1;
    if (strb !== 5'b00100 || ram_adr !== 18'h08010 || a_ack !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL rd_c2: got strb=%b adr=%h ack=%b want 00100 08010 0", strb, ram_adr, a_ack);
    end
    tick();
    total = total + 1;
    if (strb !== 5'b11111 || a_ack !== 1'b1 || b_ack !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL rd_c3: got strb=%b a_ack=%b b_ack=%b want 11111 1 0", strb, a_ack, b_ack);
    end
    tick();
    total = total + 1;
    if (a_ack !== 1'b0 || a_rdata !== 16'h1234 || strb !== 5'b11111) begin
      bad = bad + 1;
      $display("FAIL rd_c4: got a_ack=%b rdata=%h strb=%b want 0 1234 11111", a_ack, a_rdata, strb);
    end
  endtask

  task automatic test_byte_write();
    mem[18'h20005] = 16'h1177;
    sbq.push_back('{port_b: 1'b1, is_read: 1'b0, data: 16'h0});
    drive_b(1, 1, 18'h20005, 2'b10, 16'hABCD);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) drive_b(0, 0, 18'h0, 2'b00, 16'h0);
      if (c <= 2) begin
        total = total + 1;
        if (strb !== 5'b01010 || ram_dout !== 16'hABCD || ram_adr !== 18'h20005) begin
          bad = bad + 1;
          $display("FAIL bw_window c%0d: got strb=%b dout=%h adr=%h want 01010 abcd 20005",
                   c, strb, ram_dout, ram_adr);
        end
      end else if (c == 3) begin
        total = total + 1;
        if (b_ack !== 1'b1 || a_ack !== 1'b0) begin
          bad = bad + 1; $display("FAIL bw_ack: got b_ack=%b a_ack=%b want 1 0", b_ack, a_ack);
        end
      end
    end
    // full-word read back, then a be=00 read that must still capture ram_din
    sbq.push_back('{port_b: 1'b0, is_read: 1'b1, data: 16'hAB77});
    drive_a(1, 0, 18'h20005, 2'b11, 16'h0);
    tick();
    drive_a(0, 0, 18'h0, 2'b00, 16'h0);
    tick(); tick(); tick();
    sbq.push_back('{port_b: 1'b0, is_read: 1'b1, data: 16'hAB77});
    drive_a(1, 0, 18'h20005, 2'b00, 16'h0);
    tick();
    total = total + 1;
    if (strb !== 5'b00111) begin
      bad = bad + 1; $display("FAIL rd_be00_strobes: got %b want 00111", strb);
    end
    drive_a(0, 0, 18'h0, 2'b00, 16'h0);
    tick(); tick(); tick();
  endtask

  // both requesters held: grants must alternate A, B, A
  task automatic test_contention();
    int ack_cyc[3];
    int n = 0;
    pulse_reset();
    sbq.push_back('{port_b: 1'b0, is_read: 1'b1, data: 16'h1234});
    sbq.push_back('{port_b: 1'b1, is_read: 1'b1, data: 16'hAB77});
    sbq.push_back('{port_b: 1'b0, is_read: 1'b1, data: 16'h1234});
    drive_a(1, 0, 18'h08010, 2'b11, 16'h0);
    drive_b(1, 0, 18'h20005, 2'b11, 16'h0);
    for (int c = 1; c <= 16 && n < 3; c++) begin
      tick();
      if (c == 5) begin
        total = total + 1;
        if (strb !== 5'b00100 || ram_adr !== 18'h20005) begin
          bad = bad + 1; $display("FAIL cont_b_c5: got strb=%b adr=%h want 00100 20005", strb, ram_adr);
        end
      end
      if (a_ack === 1'b1 || b_ack === 1'b1) begin
        ack_cyc[n] = c;
        n++;
        if (b_ack === 1'b1) drive_b(0, 0, 18'h0, 2'b00, 16'h0);
        if (n == 3) drive_a(0, 0, 18'h0, 2'b00, 16'h0);
      end
    end
    total = total + 1;
    if (n != 3 || ack_cyc[0] != 3 || ack_cyc[1] != 7 || ack_cyc[2] != 11) begin
      bad = bad + 1;
      $display("FAIL cont_timing: got n=%0d cycles %0d,%0d,%0d want 3 acks at 3,7,11",
               n, ack_cyc[0], ack_cyc[1], ack_cyc[2]);
    end
    drive_a(0, 0, 18'h0, 2'b00, 16'h0);
    drive_b(0, 0, 18'h0, 2'b00, 16'h0);
    tick();
  endtask

  // A holds req; B raises once during A's access and must be next
  task automatic test_starvation();
    int b_ack_c = -1;
    int a_acks = 0;
    int a2_c = -1;
    pulse_reset();
    sbq.push_back('{port_b: 1'b0, is_read: 1'b1, data: 16'h1234});
    sbq.push_back('{port_b: 1'b1, is_read: 1'b1, data: 16'hAB77});
    sbq.push_back('{port_b: 1'b0, is_read: 1'b1, data: 16'h1234});
    drive_a(1, 0, 18'h08010, 2'b11, 16'h0);
    for (int c = 1; c <= 16 && a_acks < 2; c++) begin
      tick();
      if (c == 1) drive_b(1, 0, 18'h20005, 2'b11, 16'h0);
      if (b_ack === 1'b1) begin
        b_ack_c = c;
        drive_b(0, 0, 18'h0, 2'b00, 16'h0);
      end
      if (a_ack === 1'b1) begin
        a_acks++;
        if (a_acks == 2) begin
          a2_c = c;
          drive_a(0, 0, 18'h0, 2'b00, 16'h0);
        end
      end
    end
    total = total + 1;
    if (b_ack_c != 7 || a2_c != 11) begin
      bad = bad + 1;
      $display("FAIL starve: got b_ack cycle %0d, 2nd a_ack cycle %0d want 7 11", b_ack_c, a2_c);
    end
    drive_a(0, 0, 18'h0, 2'b00, 16'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive_a(1, 1, 18'h00100, 2'b11, 16'h5555);
    tick();
    total = total + 1;
    if (strb !== 5'b01000) begin
      bad = bad + 1; $display("FAIL rm_wr_c1: got strb=%b want 01000", strb);
    end
    drive_a(0, 0, 18'h0, 2'b00, 16'h0);
    tick();
    reset = 1'b1;
    tick();
    total = total + 1;
    if (strb !== 5'b11111 || {a_ack, b_ack} !== 2'b00 || a_rdata !== 16'h0 || b_rdata !== 16'h0) begin
      bad = bad + 1;
      $display("FAIL rm_c3: got strb=%b ack=%b%b rdata=%h/%h want 11111 00 0/0",
               strb, a_ack, b_ack, a_rdata, b_rdata);
    end
    reset = 1'b0;
    sbq.push_back('{port_b: 1'b0, is_read: 1'b1, data: 16'h1234});
    drive_a(1, 0, 18'h08010, 2'b11, 16'h0);
    tick();
    total = total + 1;
    if (strb !== 5'b00100) begin
      bad = bad + 1; $display("FAIL rm_next_c1: got strb=%b want 00100", strb);
    end
    drive_a(0, 0, 18'h0, 2'b00, 16'h0);
    tick(); tick();
    total = total + 1;
    if (a_ack !== 1'b1) begin
      bad = bad + 1; $display("FAIL rm_next_ack: got %b want 1", a_ack);
    end
    tick();
  endtask

  task automatic test_params();
    pulse_reset();
    p_req = 1'b1; p_we = 1'b0; p_addr = 18'h30F0F; p_be = 2'b11; p_wdata = 16'h0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) p_req = 1'b0;
      total = total + 1;
      if ((p1_ack !== (c == 2)) || (p4_ack !== (c == 5))) begin
        bad = bad + 1;
        $display("FAIL prm_rd_ack c%0d: got p1=%b p4=%b want %b %b", c, p1_ack, p4_ack, c == 2, c == 5);
      end
      total = total + 1;
      if ((p1_strb !== (c <= 1 ? 5'b00100 : 5'b11111)) || (p4_strb !== (c <= 4 ? 5'b00100 : 5'b11111))) begin
        bad = bad + 1;
        $display("FAIL prm_rd_strb c%0d: got p1=%b p4=%b", c, p1_strb, p4_strb);
      end
    end
    total = total + 1;
    if (p1_rdata !== 16'hCCCC || p4_rdata !== 16'hCCCC) begin
      bad = bad + 1; $display("FAIL prm_rdata: got %h/%h want cccc/cccc", p1_rdata, p4_rdata);
    end
    // be=00 write: full sequence, LB/UB never asserted
    p_req = 1'b1; p_we = 1'b1; p_addr = 18'h00005; p_be = 2'b00; p_wdata = 16'h1234;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) p_req = 1'b0;
      total = total + 1;
      if ((p1_ack !== (c == 2)) || (p4_ack !== (c == 5))) begin
        bad = bad + 1;
        $display("FAIL prm_wr_ack c%0d: got p1=%b p4=%b want %b %b", c, p1_ack, p4_ack, c == 2, c == 5);
      end
      total = total + 1;
      if ((p1_strb !== (c <= 1 ? 5'b01011 : 5'b11111)) || (p4_strb !== (c <= 4 ? 5'b01011 : 5'b11111))) begin
        bad = bad + 1;
        $display("FAIL prm_wr_strb c%0d: got p1=%b p4=%b", c, p1_strb, p4_strb);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_starvation();
    test_reset_mid();
    test_params();
    tick();
    total = total + 1;
    if (sbq.size() != 0) begin
      bad = bad + 1; $display("FAIL sb_drain: got %0d outstanding acks want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
